// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the processor load/store port. A request is
// accepted with a valid/ready handshake, held for WAIT_CYCLES wait states,
// and then performed against a word-organised RAM with byte-enable writes.
// The result is presented with a second valid/ready handshake and held there
// under back-pressure.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   req_valid  initiator presents a request
//   req_ready  responder can accept a request this cycle (IDLE only)
//   req_write  1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     store byte enables, be[i] covers wdata[8i+7:8i]
//   rsp_valid  response available (RESP only)
//   rsp_ready  initiator accepts the response
//   rsp_rdata  load data; 0 for stores and errored accesses
//   rsp_err    misaligned or out-of-range access
//
// Build option: DMEM_BUS_ERR_EN
//   defined   - misaligned (addr[1:0] != 0) and out-of-range (word index
//               >= DEPTH_WORDS) accesses are flagged on rsp_err and never
//               write the RAM.
//   undefined - no checking: addr[1:0] is ignored (force-aligned), the word
//               index is addr[AW+1:2] (wraps modulo DEPTH_WORDS), rsp_err = 0.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2,
   parameter int AW          = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   // Counter only ever holds WAIT_CYCLES-1 down to 0.
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   wait_cnt;

   // Request captured at the accept edge.
   logic            lat_write;
   logic [AW-1:0]   lat_idx;
   logic [31:0]     lat_wdata;
   logic [3:0]      lat_be;
   logic            lat_err;

   // Response registers.
   logic [31:0]     rdata_q;
   logic            err_q;

   // Decoded live request.
   logic [AW-1:0]   req_idx;
   logic            req_err;

   // Operands of the access actually performed this edge.
   logic            acc_write;
   logic [AW-1:0]   acc_idx;
   logic [31:0]     acc_wdata;
   logic [3:0]      acc_be;
   logic            acc_err;

   logic            accept;
   logic            do_access;

   logic [31:0]     mem [DEPTH_WORDS];

   assign req_idx = req_addr[AW+1:2];

`ifdef DMEM_BUS_ERR_EN
   localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
   assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_LIM);
`else
   assign req_err = 1'b0;
   // Address bits outside the word index are deliberately ignored.
   logic unused_addr;
   assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

   // With zero wait states the access happens on the accept edge itself, so
   // it must use the live request; otherwise the captured copy is used.
   always_comb begin
      if (state == IDLE) begin
         acc_write = req_write;
         acc_idx   = req_idx;
         acc_wdata = req_wdata;
         acc_be    = req_be;
         acc_err   = req_err;
      end else begin
         acc_write = lat_write;
         acc_idx   = lat_idx;
         acc_wdata = lat_wdata;
         acc_be    = lat_be;
         acc_err   = lat_err;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave one unassigned and infer a latch.
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      do_access = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt = RESP;
                  do_access = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               state_nxt = RESP;
               do_access = 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt  <= '0;
         lat_write <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         lat_err   <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            lat_write <= req_write;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            lat_err   <= req_err;
            wait_cnt  <= CW'(WAIT_CYCLES - 1);
         end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end

         if (do_access) begin
            err_q   <= acc_err;
            rdata_q <= (acc_write || acc_err) ? 32'h0 : mem[acc_idx];
         end else if (state == RESP && rsp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
         end
      end
   end

   // NOTE: the RAM array has no reset; only the write is gated by reset so a
   // store interrupted in WAIT never commits.
   always_ff @(posedge clk) begin
      if (reset && do_access && acc_write && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. A WAIT_CYCLES=2 instance carries the
// functional scenarios; a WAIT_CYCLES=0 instance covers zero-wait latency and
// back-to-back throughput. Error expectations follow DMEM_BUS_ERR_EN.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int WAIT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // WAIT_CYCLES=2 instance
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   // WAIT_CYCLES=0 instance
   logic        req_valid_z, req_ready_z, req_write_z;
   logic [31:0] req_addr_z, req_wdata_z;
   logic [3:0]  req_be_z;
   logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
   logic [31:0] rsp_rdata_z;

   int checks   = 0;
   int failures = 0;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT), .AW(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .AW(8)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
      .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
      .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
      .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One full transaction on the WAIT_CYCLES=2 instance. Called at a negedge,
   // returns at a negedge in IDLE. Request inputs are scrambled after the
   // accept edge so any late use of them shows up. hold = cycles of rsp_ready=0
   // after rsp_valid is first seen.
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input int hold,
                      output logic [31:0] rd, output logic e);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL txn_ready addr=%h: req_ready=%b want 1", a, req_ready);
      end
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = b;
      @(negedge clk);
      req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFC;
      req_wdata = 32'hA5A5_A5A5; req_be = 4'hF;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != WAIT + 1) begin
         failures++;
         $display("FAIL txn_latency addr=%h: cycles=%0d want %0d", a, n, WAIT + 1);
      end
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL txn_resp_ready addr=%h: req_ready=%b want 0", a, req_ready);
      end
      rd = rsp_rdata;
      e  = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== rd || rsp_err !== e) begin
            failures++;
            $display("FAIL backpressure cycle %0d: valid=%b ready=%b rdata=%h err=%b want 1 0 %h %b",
                     i, rsp_valid, req_ready, rsp_rdata, rsp_err, rd, e);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL txn_after_handshake addr=%h: ready=%b valid=%b err=%b rdata=%h want 1 0 0 0",
                  a, req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      rsp_ready = 1'b0;
      req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
      rsp_ready_z = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL reset_state: ready=%b valid=%b err=%b rdata=%h want 1 0 0 0",
                  req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
      checks++;
      if ({req_ready_z, rsp_valid_z, rsp_err_z, rsp_rdata_z} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL reset_state_w0: ready=%b valid=%b err=%b rdata=%h want 1 0 0 0",
                  req_ready_z, rsp_valid_z, rsp_err_z, rsp_rdata_z);
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd;
      logic        e;
      txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, e);
      checks++;
      if (rd !== 32'h0 || e !== 1'b0) begin
         failures++;
         $display("FAIL store_rsp: rdata=%h err=%b want 0 0", rd, e);
      end
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
         failures++;
         $display("FAIL load_back: rdata=%h err=%b want deadbeef 0", rd, e);
      end
   endtask

   task automatic test_byte_enables();
      logic [31:0] rd;
      logic        e;
      txn(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, rd, e);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'hDE22_BE44) begin
         failures++;
         $display("FAIL byte_enable: rdata=%h want de22be44", rd);
      end
      // Store with no byte enables is legal and changes nothing.
      txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, rd, e);
      checks++;
      if (rd !== 32'h0 || e !== 1'b0) begin
         failures++;
         $display("FAIL zero_be_rsp: rdata=%h err=%b want 0 0", rd, e);
      end
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'hDE22_BE44) begin
         failures++;
         $display("FAIL zero_be_ram: rdata=%h want de22be44", rd);
      end
   endtask

   task automatic test_back_pressure();
      logic [31:0] rd;
      logic        e;
      txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, e);
      checks++;
      if (rd !== 32'hDE22_BE44 || e !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_data: rdata=%h err=%b want de22be44 0", rd, e);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        e;
      // Highest valid word is an ordinary access in either build.
      txn(1'b1, 32'h3FC, 32'h600D_CAFE, 4'hF, 0, rd, e);
      txn(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'h600D_CAFE || e !== 1'b0) begin
         failures++;
         $display("FAIL last_word: rdata=%h err=%b want 600dcafe 0", rd, e);
      end
      txn(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 0, rd, e);
`ifdef DMEM_BUS_ERR_EN
      txn(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 0, rd, e);
      checks++;
      if (rd !== 32'h0 || e !== 1'b1) begin
         failures++;
         $display("FAIL misaligned_store: rdata=%h err=%b want 0 1", rd, e);
      end
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'hDE22_BE44 || e !== 1'b0) begin
         failures++;
         $display("FAIL misaligned_no_write: rdata=%h err=%b want de22be44 0", rd, e);
      end
      txn(1'b0, 32'h400, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'h0 || e !== 1'b1) begin
         failures++;
         $display("FAIL range_load: rdata=%h err=%b want 0 1", rd, e);
      end
      // 0x1000 aliases word 0 in its low index bits; it must not write.
      txn(1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0, rd, e);
      checks++;
      if (rd !== 32'h0 || e !== 1'b1) begin
         failures++;
         $display("FAIL range_store: rdata=%h err=%b want 0 1", rd, e);
      end
      txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin
         failures++;
         $display("FAIL range_no_write: rdata=%h err=%b want cafef00d 0", rd, e);
      end
`else
      txn(1'b0, 32'h402, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin
         failures++;
         $display("FAIL wrap_load: rdata=%h err=%b want cafef00d 0", rd, e);
      end
      txn(1'b1, 32'h13, 32'h0F0F_0F0F, 4'hF, 0, rd, e);
      checks++;
      if (rd !== 32'h0 || e !== 1'b0) begin
         failures++;
         $display("FAIL aligned_store_rsp: rdata=%h err=%b want 0 0", rd, e);
      end
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'h0F0F_0F0F) begin
         failures++;
         $display("FAIL force_aligned: rdata=%h want 0f0f0f0f", rd);
      end
`endif
   endtask

   task automatic test_wait0_back_to_back();
      logic        w_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] a_t [4] = '{32'h8, 32'h8, 32'hC, 32'hC};
      logic [31:0] d_t [4] = '{32'h1357_2468, 32'h0, 32'hAABB_CCDD, 32'h0};
      logic [31:0] x_t [4] = '{32'h0, 32'h1357_2468, 32'h0, 32'hAABB_CCDD};
      rsp_ready_z = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (req_ready_z !== 1'b1 || rsp_valid_z !== 1'b0) begin
            failures++;
            $display("FAIL w0_idle txn %0d: ready=%b valid=%b want 1 0", i, req_ready_z, rsp_valid_z);
         end
         req_valid_z = 1'b1; req_write_z = w_t[i]; req_addr_z = a_t[i];
         req_wdata_z = d_t[i]; req_be_z = 4'hF;
         @(negedge clk);
         checks++;
         if (rsp_valid_z !== 1'b1 || req_ready_z !== 1'b0 || rsp_rdata_z !== x_t[i] || rsp_err_z !== 1'b0) begin
            failures++;
            $display("FAIL w0_resp txn %0d: valid=%b ready=%b rdata=%h err=%b want 1 0 %h 0",
                     i, rsp_valid_z, req_ready_z, rsp_rdata_z, rsp_err_z, x_t[i]);
         end
         @(negedge clk);
      end
      req_valid_z = 1'b0;
      checks++;
      if (req_ready_z !== 1'b1 || rsp_valid_z !== 1'b0) begin
         failures++;
         $display("FAIL w0_final: ready=%b valid=%b want 1 0", req_ready_z, rsp_valid_z);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd;
      logic        e;
      txn(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 0, rd, e);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
      req_wdata = 32'h5A5A_5A5A; req_be = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_op_wait: valid=%b ready=%b want 0 0", rsp_valid, req_ready);
      end
      // Reset lands on the edge that would have performed the store.
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL mid_op_reset: ready=%b valid=%b err=%b rdata=%h want 1 0 0 0",
                  req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_op_release: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
      end
      txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e);
      checks++;
      if (rd !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL mid_op_ram: rdata=%h want 0badf00d", rd);
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_enables();
      test_back_pressure();
      test_errors();
      test_wait0_back_to_back();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
